// File: rtl/control_unit.sv
// Multi-cycle RV32I-style control FSM: Moore state decode of datapath enables and selects,
// with a configurable number of data-memory wait cycles on loads and a sticky illegal-instruction trap.
module control_unit #(
    parameter int DMEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op_code,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       Zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       IR_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       trap
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWAIT, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_JALR, S_LINK, S_BRANCH, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [2:0] WAIT_LOAD = (DMEM_WAIT > 0) ? 3'(DMEM_WAIT - 1) : 3'd0;

    state_t     state_r;
    logic [2:0] wait_cnt_r;
    logic       pc_write_s, adr_src_s, mem_write_s, ir_write_s, reg_write_s, trap_s;
    logic       unused_funct7_s;

    assign unused_funct7_s = ^{funct7[6], funct7[4:0]};

    // ALU operation for register/immediate arithmetic; sub only when the R-type funct7 bit asks for it.
    function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic sub_en);
        case (f3)
            3'b000:         alu_op = sub_en ? 3'b001 : 3'b000;
            3'b111:         alu_op = 3'b010;
            3'b110:         alu_op = 3'b011;
            3'b100:         alu_op = 3'b100;
            3'b010:         alu_op = 3'b101;
            3'b011:         alu_op = 3'b110;
            3'b001, 3'b101: alu_op = 3'b111;
            default:        alu_op = 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] branch_op(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001: branch_op = 3'b001;
            3'b100, 3'b101: branch_op = 3'b101;
            3'b110, 3'b111: branch_op = 3'b110;
            default:        branch_op = 3'b000;
        endcase
    endfunction

    // beq/bge/bgeu take on a zero compare result, bne/blt/bltu on non-zero.
    function automatic logic branch_taken(input logic [2:0] f3, input logic zero);
        case (f3)
            3'b000, 3'b101, 3'b111: branch_taken = zero;
            3'b001, 3'b100, 3'b110: branch_taken = ~zero;
            default:                branch_taken = 1'b0;
        endcase
    endfunction

    // State register and load wait counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_FETCH;
            wait_cnt_r <= 3'd0;
        end else begin
            case (state_r)
                S_FETCH:  state_r <= S_DECODE;
                S_DECODE: begin
                    case (op_code)
                        OP_LOAD, OP_STORE: state_r <= S_MEMADR;
                        OP_R:              state_r <= S_EXECR;
                        OP_I:              state_r <= S_EXECI;
                        OP_JAL:            state_r <= S_JAL;
                        OP_JALR:           state_r <= S_JALR;
                        OP_BRANCH:         state_r <= S_BRANCH;
                        default:           state_r <= S_TRAP;
                    endcase
                end
                S_MEMADR:  state_r <= (op_code == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD: begin
                    wait_cnt_r <= WAIT_LOAD;
                    state_r    <= (DMEM_WAIT > 0) ? S_MEMWAIT : S_MEMWB;
                end
                S_MEMWAIT: begin
                    if (wait_cnt_r == 3'd0) begin
                        state_r <= S_MEMWB;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 3'd1;
                    end
                end
                S_MEMWB, S_MEMWRITE:         state_r <= S_FETCH;
                S_EXECR, S_EXECI, S_JAL, S_LINK: state_r <= S_ALUWB;
                S_ALUWB:                     state_r <= S_FETCH;
                S_JALR:                      state_r <= S_LINK;
                S_BRANCH: state_r <= (funct3 == 3'b010 || funct3 == 3'b011) ? S_TRAP : S_FETCH;
                S_TRAP:                      state_r <= S_TRAP;
                default:                     state_r <= S_FETCH;
            endcase
        end
    end

    // Moore output decode; anything not set in a state stays 0.
    always_comb begin
        pc_write_s  = 1'b0;
        adr_src_s   = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;
        trap_s      = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        imm_src     = 2'b00;
        alu_control = 3'b000;
        case (state_r)
            S_FETCH: begin
                ir_write_s = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_write_s = 1'b1;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = (op_code == OP_JAL) ? 2'b11 : 2'b10;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = (op_code == OP_STORE) ? 2'b01 : 2'b00;
            end
            S_MEMREAD, S_MEMWAIT: adr_src_s = 1'b1;
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_s = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src_s   = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = alu_op(funct3, funct7[5]);
            end
            S_EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_op(funct3, 1'b0);
            end
            S_ALUWB: reg_write_s = 1'b1;
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write_s = 1'b1;
            end
            S_JALR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write_s = 1'b1;
            end
            S_LINK: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            S_BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = branch_op(funct3);
                pc_write_s  = branch_taken(funct3, Zero);
            end
            S_TRAP:  trap_s = 1'b1;
            default: trap_s = 1'b0;
        endcase
    end

    // Enables and trap are gated by reset so nothing commits while reset is held.
    assign pc_write  = pc_write_s  & ~reset;
    assign adr_src   = adr_src_s;
    assign mem_write = mem_write_s & ~reset;
    assign IR_write  = ir_write_s  & ~reset;
    assign reg_write = reg_write_s & ~reset;
    assign trap      = trap_s      & ~reset;

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter DMEM_WAIT, default 1: number of MEMWAIT cycles inserted after MEMREAD before load writeback (0..7).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports op_code in 7, funct3 in 3, funct7 in 7: fields of the instruction register.
REQ-005 SHALL have port Zero  in  1  ALU result == 0.
REQ-006 SHALL have ports pc_write, adr_src, mem_write, IR_write, reg_write  out  1 each: datapath enables/selects.
REQ-007 SHALL have ports result_src, alu_src_a, alu_src_b, imm_src  out  2 each, and alu_control  out  3.
REQ-008 SHALL have port trap  out  1  high while halted on an illegal instruction.

Function
REQ-009 SHALL be a Moore FSM; all outputs decode from state, op_code, and funct fields; pc_write alone also depends on Zero (BRANCH).
REQ-010 SHALL use encodings: alu_src_a 00 PC, 01 oldPC, 10 rs1; alu_src_b 00 rs2, 01 imm, 10 const 4; result_src 00 ALUOut, 01 mem data, 10 ALU result; imm_src 00 I, 01 S, 10 B, 11 J.
REQ-011 SHALL use alu_control 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sltu, 111 shift (ALU selects shift type from funct3/funct7).
REQ-012 SHALL default every unlisted output to 0 in every state.
REQ-013 FETCH: adr_src 0, IR_write 1, a 00, b 10, add, result_src 10, pc_write 1; -> DECODE.
REQ-014 DECODE: a 01, b 01, add, imm_src 11 if op 1101111 else 10; -> by opcode: 0000011/0100011 MEMADR, 0110011 EXECR, 0010011 EXECI, 1101111 JAL, 1100111 JALR, 1100011 BRANCH, any other TRAP.
REQ-015 MEMADR: a 10, b 01, add, imm_src 00 (load) or 01 (store); -> MEMREAD (load) or MEMWRITE (store).
REQ-016 MEMREAD: adr_src 1, result_src 00; -> MEMWAIT if DMEM_WAIT>0 else MEMWB; MEMWAIT holds the same outputs for DMEM_WAIT cycles via a down-counter loaded in MEMREAD.
REQ-017 MEMWB: result_src 01, reg_write 1; -> FETCH. MEMWRITE: adr_src 1, result_src 00, mem_write 1; -> FETCH.
REQ-018 EXECR: a 10, b 00; funct3 000 -> sub if funct7[5] else add; 111 and; 110 or; 100 xor; 010 slt; 011 sltu; 001/101 shift; -> ALUWB.
REQ-019 EXECI: a 10, b 01, imm_src 00; same funct3 map, funct7[5] ignored for 000; -> ALUWB.
REQ-020 ALUWB: result_src 00, reg_write 1; -> FETCH.
REQ-021 JAL: a 01, b 10, add, result_src 00, pc_write 1; -> ALUWB (link = oldPC+4).
REQ-022 JALR: a 10, b 01, imm_src 00, add, result_src 10, pc_write 1; -> LINK. LINK: a 01, b 10, add; -> ALUWB.
REQ-023 BRANCH: a 10, b 00, result_src 00; beq/bne sub, blt/bge slt, bltu/bgeu sltu; pc_write = Zero for beq/bge/bgeu, ~Zero for bne/blt/bltu; -> FETCH.
REQ-024 BRANCH with funct3 010 or 011 SHALL go to TRAP with pc_write 0.
REQ-025 TRAP: trap 1, all enables 0; remains in TRAP until reset.
REQ-026 Latencies (cycles incl. FETCH): load 5+DMEM_WAIT, store 4, R/I-ALU 4, jal 4, jalr 5, branch 3.

Reset
REQ-027 reset high at a rising edge SHALL load state FETCH and clear the wait counter, from any state including mid-instruction and TRAP.
REQ-028 While reset is high, pc_write, mem_write, IR_write, reg_write SHALL be forced 0 combinationally and trap SHALL be 0.
REQ-029 First cycle after reset release SHALL present FETCH outputs.

Verification
REQ-030 reset 2 cycles, op 0110011 f3 000 f7 0100000 -> FETCH, DECODE, EXECR alu_control 001, ALUWB reg_write 1, FETCH.
REQ-031 DMEM_WAIT=2, op 0000011 -> MEMADR, MEMREAD, 2x MEMWAIT adr_src 1, MEMWB result_src 01 reg_write 1; 7 cycles total.
REQ-032 op 1100011 f3 001, Zero 0 -> BRANCH alu_control 001 pc_write 1; repeat with Zero 1 -> pc_write 0.
REQ-033 op 1100111 -> JALR pc_write 1 result_src 10, LINK a 01 b 10, ALUWB reg_write 1.
REQ-034 op 0110111 -> TRAP, trap 1 held 10 cycles, all enables 0; reset -> FETCH, trap 0.
REQ-035 reset asserted during MEMWRITE -> mem_write 0 same cycle, FETCH next cycle.
